soi_event_capture: RTL



---
 rtl/soi_cap_pkg.sv | 24 ++
 rtl/soi_cap_fifo.sv | 62 ++++++
 rtl/soi_event_capture.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/soi_cap_pkg.sv
// Shared types and width constants for the SOI event capture block.
package soi_cap_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2
  } soi_cap_state_e;

  localparam int DROP_CNT_W = 16;
  localparam int SOI_W_DEF  = 8;
  localparam int TS_W_DEF   = 32;

  // Record layout is {ts, soi}; the default-width struct documents the packing.
  typedef struct packed {
    logic [TS_W_DEF-1:0]  ts;
    logic [SOI_W_DEF-1:0] soi;
  } soi_cap_rec_t;

  function automatic int rec_w(input int ts_w, input int soi_w);
    return ts_w + soi_w;
  endfunction

endpackage

// File: rtl/soi_cap_fifo.sv
// Synchronous FIFO with registered storage, push/full/level interface and
// a valid/ready pop port. A push while full is accepted only alongside a pop.
module soi_cap_fifo #(
  parameter int  W     = 40,
  parameter int  DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  output logic          full_o,
  input  logic          ready_i,
  output logic          valid_o,
  output logic [W-1:0]  dout_o,
  output logic [LW-1:0] level_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign valid_o = (cnt_q != '0);
  assign full_o  = (cnt_q == LW'(DEPTH));
  assign do_pop  = valid_o && ready_i;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rd_ptr_q];
  assign level_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + LW'(1);
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - LW'(1);
    end
  end

  // Storage is reset so the head word reads as zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/soi_event_capture.sv
// Captures masked changes on probed SOI bits as {timestamp, soi} records.
// Define SOI_CAP_DELTA_TS_EN for delta timestamps instead of absolute ones.
module soi_event_capture
  import soi_cap_pkg::*;
#(
  parameter int SOI_W = 8,
  parameter int TS_W  = 32,
  parameter int DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SOI_W-1:0]      soi_i,
  input  logic [SOI_W-1:0]      mask_i,
  input  logic                  arm_i,
  input  logic                  disarm_i,
  output logic                  rec_valid_o,
  input  logic                  rec_ready_i,
  output logic [TS_W-1:0]       rec_ts_o,
  output logic [SOI_W-1:0]      rec_soi_o,
  output logic [DROP_CNT_W-1:0] drop_cnt_o,
  output logic [1:0]            state_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int REC_W = rec_w(TS_W, SOI_W);

  soi_cap_state_e        state_q, state_d;
  logic [SOI_W-1:0]      soi_q;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;
  logic [TS_W-1:0]       ts_val;
  logic                  chg, wr, arm_acc, full, pop, drop, accepted;
  logic [REC_W-1:0]      fifo_dout;

  assign chg      = |((soi_i ^ soi_q) & mask_i);
  assign pop      = rec_valid_o && rec_ready_i;
  assign drop     = wr && full && !pop;
  assign accepted = wr && !drop;

  always_comb begin
    state_d = state_q;
    wr      = 1'b0;
    arm_acc = 1'b0;
    case (state_q)
      IDLE: begin
        if (!disarm_i && arm_i) begin
          state_d = ARMED;
          arm_acc = 1'b1;
        end
      end
      ARMED: begin
        wr = chg;
        if (disarm_i) begin
          state_d = IDLE;
        end else if (chg) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        wr = chg;
        if (disarm_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    drop_d = drop_q;
    if (arm_acc) begin
      drop_d = '0;
    end else if (drop && (drop_q != '1)) begin
      drop_d = drop_q + DROP_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      soi_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      soi_q   <= soi_i;
      drop_q  <= drop_d;
    end
  end

`ifdef SOI_CAP_DELTA_TS_EN
  // Elapsed cycles since the last accepted record (or the arming cycle).
  logic [TS_W-1:0] el_q, el_d;

  always_comb begin
    el_d = (el_q == '1) ? el_q : el_q + TS_W'(1);
    if (arm_acc || accepted) begin
      el_d = TS_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      el_q <= '0;
    end else begin
      el_q <= el_d;
    end
  end

  assign ts_val = el_q;
`else
  logic [TS_W-1:0] ts_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + TS_W'(1);
    end
  end

  assign ts_val = ts_q;
`endif

  soi_cap_fifo #(
    .W     (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (wr),
    .din_i   ({ts_val, soi_i}),
    .full_o  (full),
    .ready_i (rec_ready_i),
    .valid_o (rec_valid_o),
    .dout_o  (fifo_dout),
    .level_o (level_o)
  );

  assign rec_ts_o   = fifo_dout[REC_W-1:SOI_W];
  assign rec_soi_o  = fifo_dout[SOI_W-1:0];
  assign drop_cnt_o = drop_q;
  assign state_o    = state_q;

endmodule
